// File: rtl/ring_fifo.sv
// rtl/ring_fifo.sv - circular FIFO with wrapping pointers and FWFT read port
module ring_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  logic [WIDTH-1:0]           wr_data,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic [WIDTH-1:0]           rd_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push, pop;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] advance(input logic [PW-1:0] ptr);
    if (ptr == PW'(DEPTH - 1)) return '0;
    return ptr + PW'(1);
  endfunction

  // Flags come straight from the registered count; the handshakes follow them.
  always_comb begin
    full     = (count_q == CW'(DEPTH));
    empty    = (count_q == '0);
    wr_ready = !full;
    rd_valid = !empty;
    count    = count_q;
    rd_data  = mem_q[rd_ptr_q];
    push     = wr_valid && wr_ready;
    pop      = rd_valid && rd_ready;
  end

  // Next pointer/count state; push and pop together leave count unchanged.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = advance(wr_ptr_q);
    if (pop)  rd_ptr_d = advance(rd_ptr_q);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage write: only the slot under the write pointer changes on a push.
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = wr_data;
  end

  // Control state, cleared asynchronously so contents are discarded at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array is deliberately not reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_ring_fifo.sv
// tb/tb_ring_fifo.sv - randomized and directed bench for ring_fifo (DEPTH 8 and 5)
module tb_ring_fifo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_valid;
  logic [7:0] wr_data;
  logic       rd_ready;

  logic       wr_ready_a, rd_valid_a, full_a, empty_a;
  logic [7:0] rd_data_a;
  logic [3:0] count_a;
  logic       wr_ready_b, rd_valid_b, full_b, empty_b;
  logic [7:0] rd_data_b;
  logic [2:0] count_b;

  int checks = 0;
  int errors = 0;

  logic [7:0] q_a[$];
  logic [7:0] q_b[$];
  logic [7:0] popped_a[$];
  logic [7:0] popped_b[$];

  always #5 clk = ~clk;

  ring_fifo #(.WIDTH(8), .DEPTH(8)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(wr_valid), .wr_ready(wr_ready_a), .wr_data(wr_data),
    .rd_valid(rd_valid_a), .rd_ready(rd_ready), .rd_data(rd_data_a),
    .count(count_a), .full(full_a), .empty(empty_a)
  );

  ring_fifo #(.WIDTH(8), .DEPTH(5)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(wr_valid), .wr_ready(wr_ready_b), .wr_data(wr_data),
    .rd_valid(rd_valid_b), .rd_ready(rd_ready), .rd_data(rd_data_b),
    .count(count_b), .full(full_b), .empty(empty_b)
  );

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, obs, obs, exp, exp, $time);
    end
  endtask

  // Compare both DUTs against the queue models (state before the coming edge).
  task automatic compare_all();
    check("a_count", int'(count_a), q_a.size());
    check("a_full", int'(full_a), int'(q_a.size() == 8));
    check("a_empty", int'(empty_a), int'(q_a.size() == 0));
    check("a_wr_ready", int'(wr_ready_a), int'(q_a.size() < 8));
    check("a_rd_valid", int'(rd_valid_a), int'(q_a.size() > 0));
    if (q_a.size() > 0) check("a_rd_data", int'(rd_data_a), int'(q_a[0]));
    check("b_count", int'(count_b), q_b.size());
    check("b_full", int'(full_b), int'(q_b.size() == 5));
    check("b_empty", int'(empty_b), int'(q_b.size() == 0));
    check("b_wr_ready", int'(wr_ready_b), int'(q_b.size() < 5));
    check("b_rd_valid", int'(rd_valid_b), int'(q_b.size() > 0));
    if (q_b.size() > 0) check("b_rd_data", int'(rd_data_b), int'(q_b[0]));
  endtask

  // One clock cycle: drive, check, clock, then advance the reference model.
  task automatic cycle(input logic wv, input logic [7:0] wd, input logic rr);
    bit push_a, pop_a, push_b, pop_b;
    @(negedge clk);
    wr_valid = wv;
    wr_data  = wd;
    rd_ready = rr;
    #1;
    compare_all();
    push_a = wv && (q_a.size() < 8);
    pop_a  = rr && (q_a.size() > 0);
    push_b = wv && (q_b.size() < 5);
    pop_b  = rr && (q_b.size() > 0);
    @(posedge clk);
    if (pop_a)  popped_a.push_back(q_a.pop_front());
    if (push_a) q_a.push_back(wd);
    if (pop_b)  popped_b.push_back(q_b.pop_front());
    if (push_b) q_b.push_back(wd);
  endtask

  task automatic drain();
    for (int i = 0; i < 10; i++) cycle(1'b0, 8'h00, 1'b1);
  endtask

  initial begin
    rst_n    = 1'b0;
    wr_valid = 1'b0;
    wr_data  = 8'h00;
    rd_ready = 1'b0;
    #3;
    check("reset_count", int'(count_a), 0);
    check("reset_empty", int'(empty_a), 1);
    check("reset_full", int'(full_a), 0);
    check("reset_wr_ready", int'(wr_ready_a), 1);
    check("reset_rd_valid", int'(rd_valid_a), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Fill DEPTH-8 to full, then a 9th write that must be dropped.
    for (int i = 0; i < 9; i++) cycle(1'b1, 8'(8'h10 + i), 1'b0);
    cycle(1'b0, 8'h00, 1'b0);
    check("t1_count", int'(count_a), 8);
    check("t1_full", int'(full_a), 1);
    check("t1_wr_ready", int'(wr_ready_a), 0);

    // Drain the full FIFO: expect 0x10..0x17 in order, 0x18 absent.
    popped_a.delete();
    for (int i = 0; i < 8; i++) cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);
    check("t2_pop_count", popped_a.size(), 8);
    for (int i = 0; i < 8 && i < popped_a.size(); i++)
      check("t2_order", int'(popped_a[i]), 16'h10 + i);
    check("t2_empty", int'(empty_a), 1);
    check("t2_rd_valid", int'(rd_valid_a), 0);
    check("t2_count", int'(count_a), 0);
    drain();

    // Wrap: 5 in, 5 out, then 6 more across the 7->0 boundary.
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'h30 + i), 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 8'h00, 1'b1);
    popped_a.delete();
    for (int i = 0; i < 6; i++) cycle(1'b1, 8'(8'hA0 + i), 1'b0);
    drain();
    check("t3_pop_count", popped_a.size(), 6);
    for (int i = 0; i < 6 && i < popped_a.size(); i++)
      check("t3_order", int'(popped_a[i]), 16'hA0 + i);

    // Simultaneous push/pop at count 3, then push+pop while full.
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'(8'h50 + i), 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b1, 8'(8'h60 + i), 1'b1);
    cycle(1'b0, 8'h00, 1'b0);
    check("t4_steady_count", int'(count_a), 3);
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'h70 + i), 1'b0);
    cycle(1'b1, 8'hEE, 1'b1);
    cycle(1'b0, 8'h00, 1'b0);
    check("t4_full_pushpop", int'(count_a), 7);
    drain();

    // DEPTH-5 sequence: push 5, pop 3, push 3, pop 5.
    popped_b.delete();
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'hC0 + i), 1'b0);
    cycle(1'b0, 8'h00, 1'b0);
    check("t5_full_b", int'(full_b), 1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'(8'hC5 + i), 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b0);
    check("t5_pop_count", popped_b.size(), 8);
    for (int i = 0; i < 8 && i < popped_b.size(); i++)
      check("t5_order", int'(popped_b[i]), 16'hC0 + i);
    drain();

    // Randomized traffic against the queue models.
    for (int i = 0; i < 400; i++)
      cycle(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 2) != 0));
    drain();

    // Asynchronous reset mid-burst with 4 words held.
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'(8'h80 + i), 1'b0);
    @(negedge clk);
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    #2;
    check("t6_pre_count", int'(count_a), 4);
    rst_n = 1'b0;
    #1;
    check("t6_count", int'(count_a), 0);
    check("t6_empty", int'(empty_a), 1);
    check("t6_wr_ready", int'(wr_ready_a), 1);
    check("t6_rd_valid", int'(rd_valid_a), 0);
    q_a.delete();
    q_b.delete();
    @(negedge clk);
    rst_n = 1'b1;
    popped_a.delete();
    cycle(1'b1, 8'h5A, 1'b0);
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b0);
    check("t6_pop_count", popped_a.size(), 1);
    if (popped_a.size() > 0) check("t6_new_word", int'(popped_a[0]), 16'h5A);
    check("t6_end_empty", int'(empty_a), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
